// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad operand entry, operator latch and ALU/multiplier handoff for a 16-bit calculator.
// Define CALC_RESULT_CHAIN_EN to let an operator in DONE reuse the result as the next first operand.
`timescale 1ns/1ps
module calc_entry_ctrl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned MAX_OPERAND = 32767
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [3:0]       keypad_input,
  input  logic             read_input,
  input  logic [2:0]       operator_input,
  input  logic             equal_input,
  output logic             complete,
  output logic [WIDTH-1:0] display_output,
  output logic             start_ALU,
  output logic             addOrSub,
  output logic [WIDTH-1:0] ALU_in1,
  output logic [WIDTH-1:0] ALU_in2,
  input  logic [WIDTH-1:0] ALU_out,
  input  logic             ALU_finish,
  output logic             start_mult,
  output logic [WIDTH-1:0] mult_in1,
  output logic [WIDTH-1:0] mult_in2,
  input  logic [WIDTH-1:0] mult_out,
  input  logic             mult_finish
);
  localparam int unsigned ACC_W  = WIDTH + 4;
  localparam int unsigned CNT_W  = 3;
  localparam logic [2:0]  OP_ADD = 3'b001;
  localparam logic [2:0]  OP_SUB = 3'b010;
  localparam logic [2:0]  OP_MUL = 3'b100;

  typedef enum logic [1:0] {S_OP1, S_OP2, S_CALC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op1_q, op1_d, op2_q, op2_d, result_q, result_d;
  logic [2:0]         oper_q, oper_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               read_prev_q, equal_prev_q;
  logic               complete_q, complete_d;
  logic [WIDTH-1:0]   display_q, display_d;
  logic               start_alu_q, start_alu_d, add_sub_q, add_sub_d;
  logic [WIDTH-1:0]   alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic               start_mult_q, start_mult_d;
  logic [WIDTH-1:0]   mult_in1_q, mult_in1_d, mult_in2_q, mult_in2_d;

  logic               read_edge, equal_edge, op_valid, digit_valid, digit_ok;
  logic [WIDTH-1:0]   cur_operand;
  logic [ACC_W-1:0]   acc_next;

  // Strobe edges, operator decode and decimal accumulate with range check
  always_comb begin
    read_edge   = read_input & ~read_prev_q;
    equal_edge  = equal_input & ~equal_prev_q;
    op_valid    = (operator_input == OP_ADD) || (operator_input == OP_SUB) ||
                  (operator_input == OP_MUL);
    cur_operand = (state_q == S_OP2) ? op2_q : op1_q;
    acc_next    = ACC_W'(cur_operand) * ACC_W'(10) + ACC_W'(keypad_input);
    digit_valid = read_edge && (keypad_input <= 4'd9);
    digit_ok    = digit_valid && (acc_next <= ACC_W'(MAX_OPERAND));
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    result_d     = result_q;
    oper_d       = oper_q;
    cnt_d        = cnt_q;
    complete_d   = complete_q;
    display_d    = display_q;
    start_alu_d  = start_alu_q;
    add_sub_d    = add_sub_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    start_mult_d = start_mult_q;
    mult_in1_d   = mult_in1_q;
    mult_in2_d   = mult_in2_q;
    case (state_q)
      S_OP1: begin
        if (op_valid) begin
          oper_d  = operator_input;
          op2_d   = '0;
          cnt_d   = '0;
          state_d = S_OP2;
        end else if (digit_ok) begin
          op1_d     = WIDTH'(acc_next);
          cnt_d     = cnt_inc;
          display_d = WIDTH'(acc_next);
        end
      end
      S_OP2: begin
        if (equal_edge) begin
          state_d = S_CALC;
          if (oper_q == OP_MUL) begin
            start_mult_d = 1'b1;
            mult_in1_d   = op1_q;
            mult_in2_d   = op2_q;
          end else begin
            start_alu_d = 1'b1;
            alu_in1_d   = op1_q;
            alu_in2_d   = op2_q;
            add_sub_d   = (oper_q == OP_SUB);
          end
        end else if (op_valid && (cnt_q == '0)) begin
          oper_d = operator_input;
        end else if (digit_ok) begin
          op2_d     = WIDTH'(acc_next);
          cnt_d     = cnt_inc;
          display_d = WIDTH'(acc_next);
        end
      end
      S_CALC: begin
        if (start_mult_q && mult_finish) begin
          result_d     = mult_out;
          display_d    = mult_out;
          complete_d   = 1'b1;
          start_mult_d = 1'b0;
          state_d      = S_DONE;
        end else if (start_alu_q && ALU_finish) begin
          result_d    = ALU_out;
          display_d   = ALU_out;
          complete_d  = 1'b1;
          start_alu_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        display_d = result_q;
`ifdef CALC_RESULT_CHAIN_EN
        if (op_valid) begin
          op1_d      = result_q;
          oper_d     = operator_input;
          op2_d      = '0;
          cnt_d      = '0;
          complete_d = 1'b0;
          state_d    = S_OP2;
        end else
`endif
        if (digit_valid) begin
          op1_d      = WIDTH'(keypad_input);
          op2_d      = '0;
          oper_d     = '0;
          cnt_d      = CNT_W'(1);
          complete_d = 1'b0;
          display_d  = WIDTH'(keypad_input);
          state_d    = S_OP1;
        end
      end
      default: state_d = S_OP1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= S_OP1;
      op1_q        <= '0;
      op2_q        <= '0;
      result_q     <= '0;
      oper_q       <= '0;
      cnt_q        <= '0;
      read_prev_q  <= 1'b0;
      equal_prev_q <= 1'b0;
      complete_q   <= 1'b0;
      display_q    <= '0;
      start_alu_q  <= 1'b0;
      add_sub_q    <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      start_mult_q <= 1'b0;
      mult_in1_q   <= '0;
      mult_in2_q   <= '0;
    end else begin
      state_q      <= state_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      result_q     <= result_d;
      oper_q       <= oper_d;
      cnt_q        <= cnt_d;
      read_prev_q  <= read_input;
      equal_prev_q <= equal_input;
      complete_q   <= complete_d;
      display_q    <= display_d;
      start_alu_q  <= start_alu_d;
      add_sub_q    <= add_sub_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      start_mult_q <= start_mult_d;
      mult_in1_q   <= mult_in1_d;
      mult_in2_q   <= mult_in2_d;
    end
  end

  assign complete       = complete_q;
  assign display_output = display_q;
  assign start_ALU      = start_alu_q;
  assign addOrSub       = add_sub_q;
  assign ALU_in1        = alu_in1_q;
  assign ALU_in2        = alu_in2_q;
  assign start_mult     = start_mult_q;
  assign mult_in1       = mult_in1_q;
  assign mult_in2       = mult_in2_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: vector table, corner-case sequences and randomized keying against a calculator model.
`timescale 1ns/1ps
module tb_calc_entry_ctrl;
  localparam int unsigned W = 16;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  logic         clk = 1'b0;
  logic         RST;
  logic [3:0]   keypad_input;
  logic         read_input, equal_input;
  logic [2:0]   operator_input;
  logic         complete, start_ALU, addOrSub, ALU_finish, start_mult, mult_finish;
  logic [W-1:0] display_output, ALU_in1, ALU_in2, ALU_out, mult_in1, mult_in2, mult_out;

  int tests = 0;
  int fails = 0;
  int mult_delay = 0;
  int mult_cnt = 0;

  calc_entry_ctrl dut (
    .clk(clk), .RST(RST), .keypad_input(keypad_input), .read_input(read_input),
    .operator_input(operator_input), .equal_input(equal_input), .complete(complete),
    .display_output(display_output), .start_ALU(start_ALU), .addOrSub(addOrSub),
    .ALU_in1(ALU_in1), .ALU_in2(ALU_in2), .ALU_out(ALU_out), .ALU_finish(ALU_finish),
    .start_mult(start_mult), .mult_in1(mult_in1), .mult_in2(mult_in2),
    .mult_out(mult_out), .mult_finish(mult_finish)
  );

  always #5 clk = ~clk;

  // Arithmetic units: combinational ALU, multiplier with programmable latency
  assign ALU_finish  = start_ALU;
  assign ALU_out     = addOrSub ? W'(ALU_in1 - ALU_in2) : W'(ALU_in1 + ALU_in2);
  assign mult_out    = W'(32'(mult_in1) * 32'(mult_in2));
  assign mult_finish = start_mult && (mult_cnt >= mult_delay);
  always @(posedge clk) begin
    if (start_mult && !mult_finish) mult_cnt <= mult_cnt + 1;
    else mult_cnt <= 0;
  end

  typedef struct {
    int         a;
    logic [2:0] op;
    int         b;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input int d);
    keypad_input = 4'(d);
    read_input = 1'b1;
    tick();
    read_input = 1'b0;
    tick();
  endtask

  task automatic key_num(input int n);
    int digs[$];
    int v;
    v = n;
    if (v == 0) digs.push_back(0);
    while (v > 0) begin
      digs.push_front(v % 10);
      v = v / 10;
    end
    foreach (digs[i]) key(digs[i]);
  endtask

  task automatic press_op(input logic [2:0] o);
    operator_input = o;
    tick();
    operator_input = 3'b000;
    tick();
  endtask

  // Leaves equal high for one edge; caller observes CALC right after
  task automatic press_eq();
    equal_input = 1'b1;
    tick();
    equal_input = 1'b0;
  endtask

  task automatic wait_done(input string name, output int waited);
    waited = 0;
    for (int i = 0; i < 64; i++) begin
      if (complete === 1'b1) break;
      tick();
      waited++;
    end
    check({name, "_complete"}, 32'(complete), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    keypad_input = 4'd0;
    read_input = 1'b0;
    equal_input = 1'b0;
    operator_input = 3'b000;
    tick();
    tick();
    RST = 1'b0;
  endtask

  function automatic int accum(input int cur, input int d, output bit taken);
    taken = (d <= 9) && (cur * 10 + d <= 32767);
    return taken ? cur * 10 + d : cur;
  endfunction

  function automatic logic [15:0] model_calc(input int a, input logic [2:0] op, input int b);
    int r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = a * b;
    endcase
    return 16'(r);
  endfunction

  initial begin
    int waited;
    vecs[0] = '{12,    OP_ADD, 34,    16'd46};
    vecs[1] = '{100,   OP_SUB, 25,    16'd75};
    vecs[2] = '{5,     OP_SUB, 9,     16'hFFFC};
    vecs[3] = '{6,     OP_MUL, 7,     16'd42};
    vecs[4] = '{300,   OP_MUL, 300,   16'h5F90};
    vecs[5] = '{32767, OP_ADD, 1,     16'h8000};
    vecs[6] = '{0,     OP_SUB, 1,     16'hFFFF};
    vecs[7] = '{32767, OP_MUL, 32767, 16'h0001};
    vecs[8] = '{255,   OP_MUL, 257,   16'hFFFF};
    vecs[9] = '{0,     OP_ADD, 99,    16'd99};

    do_reset();
    check("rst_complete", 32'(complete), 0);
    check("rst_display", 32'(display_output), 0);
    check("rst_start_alu", 32'(start_ALU), 0);
    check("rst_start_mult", 32'(start_mult), 0);
    check("rst_addorsub", 32'(addOrSub), 0);
    check("rst_alu_in1", 32'(ALU_in1), 0);
    check("rst_mult_in2", 32'(mult_in2), 0);

    // Equal in OP1, bad operator code, operator replace, same-cycle priority
    key(5);
    press_eq();
    tick();
    check("op1_eq_start", 32'(start_ALU), 0);
    check("op1_eq_complete", 32'(complete), 0);
    check("op1_eq_display", 32'(display_output), 5);
    press_op(3'b011);
    key(2);
    check("bad_op_display", 32'(display_output), 52);
    press_op(OP_ADD);
    check("op2_nodigit_display", 32'(display_output), 52);
    press_op(OP_MUL);
    key(3);
    check("op2_digit_display", 32'(display_output), 3);
    press_op(OP_ADD);
    keypad_input = 4'd4;
    read_input = 1'b1;
    press_eq();
    read_input = 1'b0;
    check("replace_start_mult", 32'(start_mult), 1);
    check("replace_start_alu", 32'(start_ALU), 0);
    check("replace_mult_in1", 32'(mult_in1), 52);
    check("replace_mult_in2", 32'(mult_in2), 3);
    wait_done("replace", waited);
    check("replace_result", 32'(display_output), 156);
    keypad_input = 4'd7;
    read_input = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    read_input = 1'b0;
    tick();
    check("hold_read_display", 32'(display_output), 7);
    check("hold_read_complete", 32'(complete), 0);

    // Vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      key_num(vecs[i].a);
      press_op(vecs[i].op);
      key_num(vecs[i].b);
      press_eq();
      if (vecs[i].op == OP_MUL) begin
        check($sformatf("v%0d_start_mult", i), 32'(start_mult), 1);
        check($sformatf("v%0d_mult_in1", i), 32'(mult_in1), 32'(W'(vecs[i].a)));
        check($sformatf("v%0d_mult_in2", i), 32'(mult_in2), 32'(W'(vecs[i].b)));
      end else begin
        check($sformatf("v%0d_start_alu", i), 32'(start_ALU), 1);
        check($sformatf("v%0d_alu_in1", i), 32'(ALU_in1), 32'(W'(vecs[i].a)));
        check($sformatf("v%0d_alu_in2", i), 32'(ALU_in2), 32'(W'(vecs[i].b)));
        check($sformatf("v%0d_addorsub", i), 32'(addOrSub), 32'(vecs[i].op == OP_SUB));
      end
      check($sformatf("v%0d_complete_early", i), 32'(complete), 0);
      wait_done($sformatf("v%0d", i), waited);
      check($sformatf("v%0d_latency", i), 32'(waited), 1);
      check($sformatf("v%0d_display", i), 32'(display_output), 32'(vecs[i].exp));
      check($sformatf("v%0d_starts_low", i), 32'({start_ALU, start_mult}), 0);
    end
    key(4); key(0); key(0); key(0); key(0);
    check("overflow_display", 32'(display_output), 4000);
    check("overflow_complete", 32'(complete), 0);

    // Result chaining from DONE
    do_reset();
    key(5);
    press_op(OP_ADD);
    key(3);
    press_eq();
    wait_done("chain_first", waited);
    check("chain_first_result", 32'(display_output), 8);
    press_op(OP_MUL);
`ifdef CALC_RESULT_CHAIN_EN
    check("chain_complete_cleared", 32'(complete), 0);
    check("chain_display_keeps", 32'(display_output), 8);
    key(2);
    press_eq();
    check("chain_start_mult", 32'(start_mult), 1);
    check("chain_mult_in1", 32'(mult_in1), 8);
    wait_done("chain_second", waited);
    check("chain_second_result", 32'(display_output), 16);
`else
    check("nochain_complete_held", 32'(complete), 1);
    check("nochain_display", 32'(display_output), 8);
    key(2);
    check("nochain_digit_display", 32'(display_output), 2);
    check("nochain_digit_complete", 32'(complete), 0);
`endif

    // Reset while the multiplier is still busy
    do_reset();
    mult_delay = 20;
    key(6);
    press_op(OP_MUL);
    key(7);
    press_eq();
    check("abort_start_mult", 32'(start_mult), 1);
    tick();
    check("abort_start_held", 32'(start_mult), 1);
    check("abort_not_complete", 32'(complete), 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_start_dropped", 32'(start_mult), 0);
    check("abort_complete", 32'(complete), 0);
    check("abort_display", 32'(display_output), 0);

    // Randomized keying against the calculator model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int a, b, nd, d;
      bit taken, b_seen;
      logic [2:0] op;
      mult_delay = int'($urandom_range(0, 3));
      a = 0;
      nd = int'($urandom_range(1, 6));
      for (int k = 0; k < nd; k++) begin
        d = (k > 0 && $urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 9));
        key(d);
        a = accum(a, d, taken);
      end
      check($sformatf("r%0d_op1_display", it), 32'(display_output), 32'(W'(a)));
      case ($urandom_range(0, 2))
        0:       op = OP_ADD;
        1:       op = OP_SUB;
        default: op = OP_MUL;
      endcase
      press_op(op);
      b = 0;
      b_seen = 1'b0;
      nd = int'($urandom_range(0, 6));
      for (int k = 0; k < nd; k++) begin
        d = ($urandom_range(0, 7) == 0) ? 13 : int'($urandom_range(0, 9));
        key(d);
        b = accum(b, d, taken);
        if (taken) b_seen = 1'b1;
      end
      check($sformatf("r%0d_op2_display", it), 32'(display_output), 32'(W'(b_seen ? b : a)));
      press_eq();
      wait_done($sformatf("r%0d", it), waited);
      check($sformatf("r%0d_result", it), 32'(display_output), 32'(model_calc(a, op, b)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
